// File: rtl/vga_frame_support_if.sv
// Handshake and sample-RAM signals shared between the display-controller FSM
// (master) and vga_frame_support (slave).
interface vga_frame_support_if;
  logic        clear_en;
  logic        clear_rst;
  logic [7:0]  clear_x;
  logic [7:0]  clear_y;
  logic [11:0] clear_color;
  logic        clear_done;
  logic        delay_en;
  logic        delay_rst;
  logic        delay_done;
  logic        wren;
  logic [7:0]  wraddress;
  logic [7:0]  wdata;
  logic        rden;
  logic [7:0]  rdaddress;
  logic [7:0]  q;

  modport master (
    output clear_en, clear_rst, delay_en, delay_rst,
    output wren, wraddress, wdata, rden, rdaddress,
    input  clear_x, clear_y, clear_color, clear_done, delay_done, q
  );

  modport slave (
    input  clear_en, clear_rst, delay_en, delay_rst,
    input  wren, wraddress, wdata, rden, rdaddress,
    output clear_x, clear_y, clear_color, clear_done, delay_done, q
  );
endinterface

// File: rtl/vga_frame_support.sv
// Clear-screen raster sweeper, inter-frame delay timer and dual-clock 256x8
// sample RAM (written on wrclock, read on clk) for the VGA sample display.
module vga_frame_support #(
  parameter int          SCR_W        = 160,
  parameter int          SCR_H        = 120,
  parameter logic [11:0] CLEAR_COLOR  = 12'h000,
  parameter int          DELAY_CYCLES = 10008
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrclock,
  vga_frame_support_if.slave fs
);
  localparam logic [7:0]  X_MAX = 8'(SCR_W - 1);
  localparam logic [7:0]  Y_MAX = 8'(SCR_H - 1);
  localparam logic [13:0] D_MAX = 14'(DELAY_CYCLES - 1);

  logic [7:0]  x_q, x_d, y_q, y_d;
  logic        clr_done_q, clr_done_d;
  logic [13:0] dcnt_q, dcnt_d;
  logic        dly_done_q, dly_done_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  mem [256];

  // Clear sweep: the last coordinate holds and sets done instead of wrapping.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    clr_done_d = clr_done_q;
    if (fs.clear_rst) begin
      x_d        = '0;
      y_d        = '0;
      clr_done_d = 1'b0;
    end else if (fs.clear_en && !clr_done_q) begin
      if (x_q == X_MAX && y_q == Y_MAX) begin
        clr_done_d = 1'b1;
      end else if (x_q == X_MAX) begin
        x_d = '0;
        y_d = y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_comb begin
    dcnt_d     = dcnt_q;
    dly_done_d = dly_done_q;
    if (fs.delay_rst) begin
      dcnt_d     = '0;
      dly_done_d = 1'b0;
    end else if (fs.delay_en && !dly_done_q) begin
      if (dcnt_q == D_MAX) dly_done_d = 1'b1;
      else                 dcnt_d     = dcnt_q + 14'd1;
    end
  end

  always_comb begin
    q_d = q_q;
    if (fs.rden) q_d = mem[fs.rdaddress];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      clr_done_q <= 1'b0;
      dcnt_q     <= '0;
      dly_done_q <= 1'b0;
      q_q        <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      clr_done_q <= clr_done_d;
      dcnt_q     <= dcnt_d;
      dly_done_q <= dly_done_d;
      q_q        <= q_d;
    end
  end

  // Write port lives entirely in the ADC clock domain and ignores rst_n.
  always_ff @(posedge wrclock) begin
    if (fs.wren) mem[fs.wraddress] <= fs.wdata;
  end

  assign fs.clear_x     = x_q;
  assign fs.clear_y     = y_q;
  assign fs.clear_color = CLEAR_COLOR;
  assign fs.clear_done  = clr_done_q;
  assign fs.delay_done  = dly_done_q;
  assign fs.q           = q_q;
endmodule

// File: tb/tb_vga_frame_support.sv
// Directed bench for vga_frame_support: a count-based reference model is
// compared every clk cycle, plus hand-computed spot checks.
module tb_vga_frame_support;
  localparam int          W  = 4;
  localparam int          H  = 3;
  localparam int          DC = 10;
  localparam logic [11:0] CC = 12'h5A3;

  logic clk = 1'b0;
  logic wrclock = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  vga_frame_support_if fs();

  vga_frame_support #(.SCR_W(W), .SCR_H(H), .CLEAR_COLOR(CC), .DELAY_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .wrclock(wrclock), .fs(fs)
  );

  always #5 clk = ~clk;
  always #6.5 wrclock = ~wrclock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: clear position is just the number of enabled edges since reset,
  // delay is the number of enabled edges saturated at DC.
  int         m_idx = 0;
  int         m_dn  = 0;
  logic [7:0] m_q   = '0;
  bit         m_qv  = 1'b0;
  bit         m_started = 1'b0;
  logic [7:0] ref_mem [256];
  bit         wval [256];

  initial for (int i = 0; i < 256; i++) wval[i] = 1'b0;

  always @(posedge wrclock) begin
    if (fs.wren) begin
      ref_mem[fs.wraddress] <= fs.wdata;
      wval[fs.wraddress]    <= 1'b1;
    end
  end

  always @(posedge clk) begin
    m_started <= 1'b1;
    if (!rst_n) begin
      m_idx <= 0;
      m_dn  <= 0;
      m_q   <= '0;
      m_qv  <= 1'b1;
    end else begin
      if (fs.clear_rst) m_idx <= 0;
      else if (fs.clear_en && m_idx < W * H) m_idx <= m_idx + 1;
      if (fs.delay_rst) m_dn <= 0;
      else if (fs.delay_en && m_dn < DC) m_dn <= m_dn + 1;
      if (fs.rden) begin
        m_q  <= ref_mem[fs.rdaddress];
        m_qv <= wval[fs.rdaddress];
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("clear_x",     32'(fs.clear_x),     32'((m_idx == W * H) ? W - 1 : m_idx % W));
      chk("clear_y",     32'(fs.clear_y),     32'((m_idx == W * H) ? H - 1 : m_idx / W));
      chk("clear_done",  32'(fs.clear_done),  32'(m_idx == W * H));
      chk("clear_color", 32'(fs.clear_color), 32'(CC));
      chk("delay_done",  32'(fs.delay_done),  32'(m_dn == DC));
      if (m_qv) chk("q", 32'(fs.q), 32'(m_q));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    fs.clear_en  = 1'b0;
    fs.clear_rst = 1'b0;
    fs.delay_en  = 1'b0;
    fs.delay_rst = 1'b0;
    fs.wren      = 1'b0;
    fs.wraddress = '0;
    fs.wdata     = '0;
    fs.rden      = 1'b0;
    fs.rdaddress = '0;
    tick(2);
    chk("rst clear_x", 32'(fs.clear_x), 32'd0);
    chk("rst clear_done", 32'(fs.clear_done), 32'd0);
    chk("rst delay_done", 32'(fs.delay_done), 32'd0);
    chk("rst q", 32'(fs.q), 32'd0);
    rst_n = 1'b1;

    // Sweep, pause at (2,1), finish.
    fs.clear_en = 1'b1;
    tick(5);
    chk("sweep5 x", 32'(fs.clear_x), 32'd1);
    chk("sweep5 y", 32'(fs.clear_y), 32'd1);
    tick(1);
    fs.clear_en = 1'b0;
    tick(5);
    chk("pause x", 32'(fs.clear_x), 32'd2);
    chk("pause y", 32'(fs.clear_y), 32'd1);
    fs.clear_en = 1'b1;
    tick(6);
    chk("done edge12", 32'(fs.clear_done), 32'd1);
    chk("done hold x", 32'(fs.clear_x), 32'd3);
    chk("done hold y", 32'(fs.clear_y), 32'd2);
    tick(3);
    fs.clear_rst = 1'b1;
    tick(1);
    chk("clear_rst done", 32'(fs.clear_done), 32'd0);
    fs.clear_rst = 1'b0;
    tick(4);
    fs.clear_rst = 1'b1;
    tick(1);
    chk("midrst x", 32'(fs.clear_x), 32'd0);
    chk("midrst y", 32'(fs.clear_y), 32'd0);
    fs.clear_rst = 1'b0;

    // Delay timer, with the clear sweep running concurrently.
    fs.delay_en = 1'b1;
    tick(9);
    chk("delay 9 edges", 32'(fs.delay_done), 32'd0);
    tick(1);
    chk("delay 10 edges", 32'(fs.delay_done), 32'd1);
    tick(3);
    fs.delay_rst = 1'b1;
    tick(1);
    chk("delay_rst", 32'(fs.delay_done), 32'd0);
    fs.delay_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      fs.delay_en = 1'(i % 2);
      tick(1);
      if (i == 17) chk("toggle 9 en", 32'(fs.delay_done), 32'd0);
    end
    chk("toggle 10 en", 32'(fs.delay_done), 32'd1);
    fs.delay_en = 1'b0;
    fs.clear_en = 1'b0;

    // RAM load on wrclock.
    for (int a = 0; a < 256; a++) begin
      @(negedge wrclock);
      fs.wren      = 1'b1;
      fs.wraddress = 8'(a);
      fs.wdata     = 8'(a) ^ 8'hA5;
    end
    @(negedge wrclock);
    fs.wren = 1'b0;
    tick(2);
    for (int a = 0; a < 256; a++) begin
      fs.rden      = 1'b1;
      fs.rdaddress = 8'(a);
      tick(1);
      if (a == 3) chk("ram[3]", 32'(fs.q), 32'h0A6);
    end
    fs.rden      = 1'b0;
    fs.rdaddress = 8'd7;
    tick(3);
    chk("rden0 hold", 32'(fs.q), 32'h05A);

    // Global reset in mid-operation.
    fs.clear_rst = 1'b1;
    tick(1);
    fs.clear_rst = 1'b0;
    fs.clear_en  = 1'b1;
    fs.delay_en  = 1'b1;
    tick(5);
    rst_n = 1'b0;
    tick(1);
    chk("grst x", 32'(fs.clear_x), 32'd0);
    chk("grst y", 32'(fs.clear_y), 32'd0);
    chk("grst q", 32'(fs.q), 32'd0);
    rst_n       = 1'b1;
    fs.clear_en = 1'b0;
    fs.delay_en = 1'b0;
    fs.rden      = 1'b1;
    fs.rdaddress = 8'd10;
    tick(1);
    chk("retain ram[10]", 32'(fs.q), 32'h0AF);
    fs.rdaddress = 8'd20;
    tick(1);
    chk("retain ram[20]", 32'(fs.q), 32'h0B1);
    fs.rden = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
